// File: rtl/spi_shift_engine.sv
// SPI master shift engine: runs one 8-bit full-duplex transfer per accepted send_data strobe.
// Build option SPI_LOOPBACK_EN: sample the engine's own mosi instead of the miso pin (self-test).
module spi_shift_engine (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       send_data,
    input  logic [7:0] mosi_data,
    input  logic       mstr,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic       spiswai,
    input  logic [1:0] spi_mode,
    input  logic [2:0] spr,
    input  logic [2:0] sppr,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss,
    output logic       tip,
    output logic       receive_data,
    output logic [7:0] miso_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [10:0] half_sel;
    logic [10:0] half_l;
    logic [10:0] baud_cnt;
    logic [4:0]  edge_cnt;
    logic        cpol_l;
    logic        cpha_l;
    logic        lsbfe_l;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;
    logic        sclk_q;
    logic        mosi_q;

    logic        freeze;
    logic        accept;
    logic        baud_wrap;
    logic        last_edge;
    logic        sample_edge;
    logic        sample_bit;

    // Half-period H = D/2 = (sppr+1) << spr, which spans 1..1024 and fits 11 bits.
    assign half_sel    = ({8'd0, sppr} + 11'd1) << spr;

    assign freeze      = spi_mode[1] | ((spi_mode == 2'b01) & spiswai);
    assign accept      = (state == IDLE) & send_data & mstr & ~freeze;
    assign baud_wrap   = (baud_cnt == (half_l - 11'd1));
    assign last_edge   = (edge_cnt == 5'd15);
    // Edge number edge_cnt+1 is odd (leading) when edge_cnt is even.
    assign sample_edge = ~edge_cnt[0] ^ cpha_l;

`ifdef SPI_LOOPBACK_EN
    assign sample_bit  = mosi_q;
`else
    assign sample_bit  = miso;
`endif

    assign sclk = sclk_q;
    assign mosi = mosi_q;

    function automatic logic first_bit(input logic [7:0] b, input logic lsb);
        return lsb ? b[0] : b[7];
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] b, input logic lsb);
        return lsb ? {1'b0, b[7:1]} : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] shift_in(input logic [7:0] b, input logic lsb,
                                            input logic bit_in);
        return lsb ? {bit_in, b[7:1]} : {b[6:0], bit_in};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next   = state;
        ss           = 1'b1;
        tip          = 1'b0;
        receive_data = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                ss  = 1'b0;
                tip = 1'b1;
                if (!mstr) begin
                    state_next = IDLE;
                end else if (!freeze && baud_wrap && last_edge) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                ss  = 1'b0;
                tip = 1'b1;
                if (!mstr) begin
                    state_next = IDLE;
                end else if (!freeze && baud_wrap) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                receive_data = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            half_l    <= '0;
            baud_cnt  <= '0;
            edge_cnt  <= '0;
            cpol_l    <= 1'b0;
            cpha_l    <= 1'b0;
            lsbfe_l   <= 1'b0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            miso_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sclk_q   <= cpol;
                    mosi_q   <= 1'b0;
                    baud_cnt <= '0;
                    edge_cnt <= '0;
                    if (accept) begin
                        half_l  <= half_sel;
                        cpol_l  <= cpol;
                        cpha_l  <= cpha;
                        lsbfe_l <= lsbfe;
                        rx_sr   <= '0;
                        // cpha=0 presents the first bit as soon as ss falls.
                        if (cpha) begin
                            tx_sr <= mosi_data;
                        end else begin
                            mosi_q <= first_bit(mosi_data, lsbfe);
                            tx_sr  <= shift_out(mosi_data, lsbfe);
                        end
                    end
                end
                XFER: begin
                    if (!mstr) begin
                        sclk_q <= cpol;
                        mosi_q <= 1'b0;
                    end else if (!freeze) begin
                        if (baud_wrap) begin
                            baud_cnt <= '0;
                            edge_cnt <= edge_cnt + 5'd1;
                            sclk_q   <= ~sclk_q;
                            if (sample_edge) begin
                                rx_sr <= shift_in(rx_sr, lsbfe_l, sample_bit);
                            end else begin
                                mosi_q <= first_bit(tx_sr, lsbfe_l);
                                tx_sr  <= shift_out(tx_sr, lsbfe_l);
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 11'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!mstr) begin
                        sclk_q <= cpol;
                        mosi_q <= 1'b0;
                    end else if (!freeze) begin
                        if (baud_wrap) begin
                            baud_cnt  <= '0;
                            miso_data <= rx_sr;
                            mosi_q    <= 1'b0;
                        end else begin
                            baud_cnt <= baud_cnt + 11'd1;
                        end
                    end
                end
                DONE: begin
                    sclk_q <= cpol_l;
                    mosi_q <= 1'b0;
                end
                default: begin
                    mosi_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: vector table of complete transfers plus abort, drop and reset sequences.
module tb_spi_shift_engine;

`ifdef SPI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic       PCLK;
    logic       PRESETn;
    logic       send_data;
    logic [7:0] mosi_data;
    logic       mstr;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic       spiswai;
    logic [1:0] spi_mode;
    logic [2:0] spr;
    logic [2:0] sppr;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic       tip;
    logic       receive_data;
    logic [7:0] miso_data;

    spi_shift_engine dut (
        .PCLK         (PCLK),
        .PRESETn      (PRESETn),
        .send_data    (send_data),
        .mosi_data    (mosi_data),
        .mstr         (mstr),
        .cpol         (cpol),
        .cpha         (cpha),
        .lsbfe        (lsbfe),
        .spiswai      (spiswai),
        .spi_mode     (spi_mode),
        .spr          (spr),
        .sppr         (sppr),
        .miso         (miso),
        .sclk         (sclk),
        .mosi         (mosi),
        .ss           (ss),
        .tip          (tip),
        .receive_data (receive_data),
        .miso_data    (miso_data)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic       lsbfe;
        logic [2:0] spr;
        logic [2:0] sppr;
        logic [7:0] tx;
        logic [7:0] slave;
        logic [7:0] exp_seq;     // mosi bits in send order, first bit in [7]
        logic [7:0] exp_rx;
        int         exp_len;     // cycles with ss low
        int         exp_period;  // sclk period in PCLK cycles
        int         freeze_edge; // 0 = no freeze
        int         stray_edge;  // 0 = no stray send_data
    } vec_t;

    vec_t vecs [9];

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] slv_byte = 8'h00;
    logic [7:0] exp_last = 8'h00;

    // Monitor: runs on the falling edge, counts sclk edges while ss is low and records mosi before each edge.
    int   cyc_cnt    = 0;
    int   mon_e      = 0;
    int   cur_len    = 0;
    int   last_len   = 0;
    int   last_edges = 0;
    int   rd_total   = 0;
    int   fall_t     = 0;
    logic mon_sclk_prev = 1'b0;
    logic mon_mosi_prev = 1'b0;
    logic mon_ss_prev   = 1'b1;
    logic mon_mosi [16];
    int   mon_edge_t [16];

    always @(negedge PCLK) begin
        cyc_cnt = cyc_cnt + 1;
        if (receive_data === 1'b1) rd_total = rd_total + 1;
        if (ss === 1'b0) begin
            if (mon_ss_prev === 1'b1) begin
                fall_t  = cyc_cnt;
                cur_len = 0;
                mon_e   = 0;
            end
            cur_len = cur_len + 1;
            if (sclk !== mon_sclk_prev) begin
                if (mon_e < 16) begin
                    mon_mosi[mon_e]   = mon_mosi_prev;
                    mon_edge_t[mon_e] = cyc_cnt;
                end
                mon_e = mon_e + 1;
            end
        end else begin
            if (mon_ss_prev === 1'b0) begin
                last_len   = cur_len;
                last_edges = mon_e;
            end
            mon_e = 0;
        end
        mon_sclk_prev = sclk;
        mon_mosi_prev = mosi;
        mon_ss_prev   = ss;
    end

    function automatic logic slave_bit(input logic [7:0] b, input logic lsb, input logic ph,
                                       input int e);
        int         idx;
        logic [2:0] k;
        idx = ph ? ((e == 0) ? 0 : (e - 1) / 2) : e / 2;
        if (idx > 7) idx = 7;
        k = 3'(idx);
        return lsb ? b[k] : b[3'd7 - k];
    endfunction

    task automatic tick();
        @(negedge PCLK);
        #1;
        miso = LOOPBACK ? 1'b0 : slave_bit(slv_byte, lsbfe, cpha, mon_e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_send();
        send_data = 1'b1;
        tick();
        send_data = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int         rd0;
        logic       got;
        logic       frz_done;
        logic       st_done;
        logic       steady;
        logic [3:0] snap;
        logic [7:0] rx;
        logic [7:0] seq;
        logic [7:0] exp_rx;
        logic       done_ss;
        rx      = 8'h00;
        done_ss = 1'b0;
        exp_rx  = LOOPBACK ? v.tx : v.exp_rx;
        cpol = v.cpol; cpha = v.cpha; lsbfe = v.lsbfe;
        spr = v.spr; sppr = v.sppr; mosi_data = v.tx; slv_byte = v.slave;
        mstr = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
        repeat (3) tick();
        check($sformatf("v%0d_idle_sclk", idx), sclk, v.cpol);
        rd0 = rd_total;
        pulse_send();
        check($sformatf("v%0d_ss_fall", idx), ss, 1'b0);
        check($sformatf("v%0d_tip", idx), tip, 1'b1);
        got = 1'b0; frz_done = 1'b0; st_done = 1'b0;
        for (int c = 0; c < v.exp_len + 100 && !got; c++) begin
            if (v.stray_edge != 0 && !st_done && mon_e >= v.stray_edge) begin
                send_data = 1'b1;
                mosi_data = 8'h00;
                st_done   = 1'b1;
            end else begin
                send_data = 1'b0;
            end
            if (v.freeze_edge != 0 && !frz_done && mon_e >= v.freeze_edge) begin
                snap     = {sclk, mosi, ss, tip};
                steady   = 1'b1;
                spi_mode = 2'b01;
                spiswai  = 1'b1;
                for (int f = 0; f < 20; f++) begin
                    tick();
                    if ({sclk, mosi, ss, tip} !== snap) steady = 1'b0;
                end
                spi_mode = 2'b00;
                spiswai  = 1'b0;
                frz_done = 1'b1;
                check($sformatf("v%0d_freeze_steady", idx), steady, 1'b1);
            end
            tick();
            if (receive_data === 1'b1) begin
                got     = 1'b1;
                rx      = miso_data;
                done_ss = ss;
            end
        end
        send_data = 1'b0;
        check($sformatf("v%0d_done_seen", idx), got, 1'b1);
        check($sformatf("v%0d_rx", idx), rx, exp_rx);
        check($sformatf("v%0d_done_ss", idx), done_ss, 1'b1);
        tick();
        check($sformatf("v%0d_strobe_width", idx), receive_data, 1'b0);
        tick();
        check($sformatf("v%0d_strobes", idx), 32'(rd_total - rd0), 32'd1);
        check($sformatf("v%0d_ss_len", idx), 32'(last_len), 32'(v.exp_len));
        check($sformatf("v%0d_edges", idx), 32'(last_edges), 32'd16);
        for (int i = 0; i < 8; i++) seq[7 - i] = mon_mosi[2 * i + (v.cpha ? 1 : 0)];
        check($sformatf("v%0d_mosi_seq", idx), seq, v.exp_seq);
        check($sformatf("v%0d_period", idx), 32'(mon_edge_t[2] - mon_edge_t[0]),
              32'(v.exp_period));
        check($sformatf("v%0d_first_edge", idx), 32'(mon_edge_t[0] - fall_t),
              32'(v.exp_period / 2));
        check($sformatf("v%0d_miso_data_hold", idx), miso_data, exp_rx);
        exp_last = exp_rx;
    endtask

    initial begin
        int rd0;

        //             cpol  cpha  lsbfe spr   sppr  tx     slave  seq    rx     len    per  frz str
        vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hB4, 8'h3C, 8'hB4, 8'h3C, 17,    2,    0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 3'd0, 3'd0, 8'hB4, 8'h5A, 8'h2D, 8'h5A, 17,    2,    0, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 8'h96, 8'h69, 8'h96, 8'h69, 102,   12,   0, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 3'd0, 3'd1, 8'h5A, 8'hA5, 8'h5A, 8'hA5, 34,    4,    0, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 3'd2, 3'd0, 8'h01, 8'h80, 8'h80, 8'h80, 68,    8,    0, 0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hC3, 8'h3A, 8'hC3, 8'h3A, 17,    2,    0, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 8'h3C, 8'hC3, 8'h3C, 8'hC3, 54,    4,    5, 0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd1, 8'h81, 8'h18, 8'h81, 8'h18, 34,    4,    0, 4};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 8'hA5, 8'h81, 8'hA5, 8'h81, 17408, 2048, 0, 0};

        PRESETn = 1'b0; send_data = 1'b0; mosi_data = 8'h00; mstr = 1'b1;
        cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; spiswai = 1'b0; spi_mode = 2'b00;
        spr = 3'd0; sppr = 3'd0; miso = 1'b0;
        repeat (3) tick();
        check("reset_sclk", sclk, 1'b0);
        check("reset_mosi", mosi, 1'b0);
        check("reset_ss", ss, 1'b1);
        check("reset_tip", tip, 1'b0);
        check("reset_receive_data", receive_data, 1'b0);
        check("reset_miso_data", miso_data, 8'h00);
        PRESETn = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Abort: mstr drops after the 8th edge.
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; spr = 3'd0; sppr = 3'd0;
        mosi_data = 8'hFF; slv_byte = 8'hFF; mstr = 1'b1;
        repeat (2) tick();
        rd0 = rd_total;
        pulse_send();
        for (int c = 0; c < 200 && mon_e < 8; c++) tick();
        check("abort_reach_edge8", 32'(mon_e), 32'd8);
        mstr = 1'b0;
        tick();
        check("abort_ss", ss, 1'b1);
        check("abort_tip", tip, 1'b0);
        repeat (5) tick();
        check("abort_no_strobe", 32'(rd_total - rd0), 32'd0);
        check("abort_miso_data_kept", miso_data, exp_last);
        check("abort_edges", 32'(last_edges), 32'd8);
        mstr = 1'b1;

        // Requests dropped in stop mode and with the master disabled.
        spi_mode = 2'b10;
        rd0 = rd_total;
        pulse_send();
        repeat (3) tick();
        check("drop_stop_ss", ss, 1'b1);
        spi_mode = 2'b00;
        mstr = 1'b0;
        pulse_send();
        repeat (3) tick();
        check("drop_mstr_ss", ss, 1'b1);
        check("drop_no_strobe", 32'(rd_total - rd0), 32'd0);
        mstr = 1'b1;

        // Reset asserted mid-transfer.
        cpol = 1'b1; cpha = 1'b0; lsbfe = 1'b0; spr = 3'd2; sppr = 3'd0;
        mosi_data = 8'hFF; slv_byte = 8'h55;
        repeat (3) tick();
        rd0 = rd_total;
        pulse_send();
        for (int c = 0; c < 200 && mon_e < 2; c++) tick();
        check("midrst_pre_sclk", sclk, 1'b1);
        PRESETn = 1'b0;
        tick();
        check("midrst_sclk", sclk, 1'b0);
        check("midrst_mosi", mosi, 1'b0);
        check("midrst_ss", ss, 1'b1);
        check("midrst_tip", tip, 1'b0);
        check("midrst_receive_data", receive_data, 1'b0);
        check("midrst_miso_data", miso_data, 8'h00);
        PRESETn = 1'b1;
        repeat (3) tick();
        check("midrst_no_strobe", 32'(rd_total - rd0), 32'd0);
        check("midrst_idle_sclk", sclk, 1'b1);

        run_vec(vecs[0], 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
